// File: rtl/multiword_add_pkg.sv
// rtl/multiword_add_pkg.sv - shared state encoding and index sizing for the multiword adder
package multiword_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-word build still needs a 1-bit index so the part-selects stay legal.
    function automatic int idx_width(input int nwords);
        return (nwords > 1) ? $clog2(nwords) : 1;
    endfunction

endpackage

// File: rtl/ripple_carry.sv
// rtl/ripple_carry.sv - WIDTH-bit ripple-carry word adder
module ripple_carry #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic c;

    always_comb begin
        c   = carry_in;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carry_out = c;
    end

endmodule

// File: rtl/multiword_add_ctrl.sv
// rtl/multiword_add_ctrl.sv - sequences one word adder over NWORDS words, LSW first
module multiword_add_ctrl
    import multiword_add_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NWORDS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    Start_i,
    input  logic [NWORDS*WIDTH-1:0] Number1_i,
    input  logic [NWORDS*WIDTH-1:0] Number2_i,
    input  logic                    Carry_i,
    output logic                    Busy_o,
    output logic                    Done_o,
    output logic [NWORDS*WIDTH-1:0] Result_o,
    output logic                    Carry_o
);

    localparam int              IDXW     = idx_width(NWORDS);
    localparam int              OPW      = NWORDS * WIDTH;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    state_t          state, state_n;
    logic [IDXW-1:0] idx;
    logic            carry_q;
    logic [OPW-1:0]  a_q, b_q, result_q;
    logic            carry_out_q;
    logic [WIDTH-1:0] word_sum;
    logic            word_co;
    logic            accept;
    logic            last_word;

    assign accept    = (state == ST_IDLE) && Start_i;
    assign last_word = (idx == LAST_IDX);

    ripple_carry #(.WIDTH(WIDTH)) u_word_add (
        .a         (a_q[idx*WIDTH +: WIDTH]),
        .b         (b_q[idx*WIDTH +: WIDTH]),
        .carry_in  (carry_q),
        .sum       (word_sum),
        .carry_out (word_co)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (Start_i)   state_n = ST_RUN;
            ST_RUN:  if (last_word) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                idx     <= '0;
                carry_q <= Carry_i;
            end else if (state == ST_RUN) begin
                idx     <= last_word ? '0 : idx + 1'b1;
                carry_q <= word_co;
            end
        end
    end

    // Operands are frozen at accept so later input changes cannot disturb the sum.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else if (accept) begin
            a_q         <= Number1_i;
            b_q         <= Number2_i;
            result_q    <= '0;
            carry_out_q <= 1'b0;
        end else if (state == ST_RUN) begin
            result_q[idx*WIDTH +: WIDTH] <= word_sum;
            if (last_word) carry_out_q <= word_co;
        end
    end

    assign Busy_o   = (state == ST_RUN);
    assign Done_o   = (state == ST_DONE);
    assign Result_o = result_q;
    assign Carry_o  = carry_out_q;

endmodule
